// File: rtl/vin_lock_pkg.sv
// Shared types and constants for the video input lock monitor.
package vin_lock_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    localparam int ERR_W = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with enable and synchronous clear that sticks at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/vin_lock_monitor.sv
// Measures FPD-Link line/frame timing, tracks lock, and gates DE so only
// whole conforming frames are written into the video input FIFO.
module vin_lock_monitor
    import vin_lock_pkg::*;
#(
    parameter int H_ACT       = 800,
    parameter int V_ACT       = 1200,
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 2000000,
    parameter int CNT_W       = 12,
    parameter int PIX_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             v_vsync,
    input  logic             v_hsync,
    input  logic             v_de,
    input  logic [PIX_W-1:0] v_pixel,
    output logic             o_vsync,
    output logic             o_hsync,
    output logic             o_de,
    output logic [PIX_W-1:0] o_pixel,
    output logic             locked,
    output logic             frame_start,
    output logic             err_line,
    output logic             err_frame,
    output logic [ERR_W-1:0] err_count,
    output logic [CNT_W-1:0] meas_h_act,
    output logic [CNT_W-1:0] meas_v_act
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic             vs_p1, hs_p1, de_p1;
    logic [PIX_W-1:0] pix_p1;
    logic             vs_p2, hs_p2, de_p2;
    logic [PIX_W-1:0] pix_p2;

    lock_state_t      state, state_n;
    logic [3:0]       good_cnt, good_n;
    logic             err_frame_n;
    logic             seen_vs, frame_bad, vs_rise_d, gate_en, gate;

    logic [CNT_W-1:0] pix_cnt, line_cnt, line_total;
    logic [TMO_W-1:0] tmo_cnt;
    logic             vs_rise, de_fall, line_bad, judge, frame_good;
    logic             tmo_run, tmo_fire;

    // stage 1 / stage 2 input pipeline
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vs_p1  <= 1'b0;
            hs_p1  <= 1'b0;
            de_p1  <= 1'b0;
            pix_p1 <= '0;
            vs_p2  <= 1'b0;
            hs_p2  <= 1'b0;
            de_p2  <= 1'b0;
            pix_p2 <= '0;
        end else begin
            vs_p1  <= v_vsync;
            hs_p1  <= v_hsync;
            de_p1  <= v_de;
            pix_p1 <= v_pixel;
            vs_p2  <= vs_p1;
            hs_p2  <= hs_p1;
            de_p2  <= de_p1;
            pix_p2 <= pix_p1;
        end
    end

    assign vs_rise = vs_p1 & ~vs_p2;
    assign de_fall = ~de_p1 & de_p2;

    sat_counter #(.W(CNT_W)) u_pix_cnt (
        .clk(clk), .rst_n(rst_n), .clr(de_fall), .en(de_p1), .cnt(pix_cnt)
    );

    sat_counter #(.W(CNT_W)) u_line_cnt (
        .clk(clk), .rst_n(rst_n), .clr(vs_rise), .en(de_fall), .cnt(line_cnt)
    );

    sat_counter #(.W(TMO_W)) u_tmo_cnt (
        .clk(clk), .rst_n(rst_n), .clr(vs_rise), .en(tmo_run), .cnt(tmo_cnt)
    );

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(err_frame), .cnt(err_count)
    );

    // A line ending in the vsync cycle still belongs to the frame being judged.
    assign line_bad   = de_fall && (pix_cnt != CNT_W'(H_ACT));
    assign line_total = (de_fall && (line_cnt != {CNT_W{1'b1}})) ? line_cnt + CNT_W'(1) : line_cnt;
    assign judge      = vs_rise && seen_vs;
    assign frame_good = !frame_bad && !line_bad && (line_total == CNT_W'(V_ACT));
    assign tmo_run    = (tmo_cnt != TMO_W'(TIMEOUT));
    assign tmo_fire   = !vs_rise && (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_comb begin
        state_n     = state;
        good_n      = good_cnt;
        err_frame_n = 1'b0;
        if (tmo_fire) begin
            state_n     = UNLOCKED;
            good_n      = '0;
            err_frame_n = 1'b1;
        end else if (judge) begin
            if (!frame_good) begin
                state_n     = UNLOCKED;
                good_n      = '0;
                err_frame_n = 1'b1;
            end else if (state != LOCKED) begin
                good_n  = good_cnt + 4'd1;
                state_n = (good_n >= 4'(LOCK_FRAMES)) ? LOCKED : ACQUIRE;
            end
        end else if (line_bad && (state == LOCKED)) begin
            state_n     = UNLOCKED;
            good_n      = '0;
            err_frame_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            good_cnt   <= '0;
            seen_vs    <= 1'b0;
            frame_bad  <= 1'b0;
            err_line   <= 1'b0;
            err_frame  <= 1'b0;
            vs_rise_d  <= 1'b0;
            gate_en    <= 1'b0;
            meas_h_act <= '0;
            meas_v_act <= '0;
        end else begin
            state     <= state_n;
            good_cnt  <= good_n;
            err_line  <= line_bad;
            err_frame <= err_frame_n;
            vs_rise_d <= vs_rise;
            if (tmo_fire) begin
                seen_vs <= 1'b0;
            end else if (vs_rise) begin
                seen_vs <= 1'b1;
            end
            if (vs_rise) begin
                frame_bad <= 1'b0;
            end else if (line_bad) begin
                frame_bad <= 1'b1;
            end
            if (de_fall) begin
                meas_h_act <= pix_cnt;
            end
            if (vs_rise) begin
                meas_v_act <= line_total;
            end
            // Gate opens only at the stage-2 vsync edge so o_de never starts mid-line.
            if (state != LOCKED) begin
                gate_en <= 1'b0;
            end else if (vs_rise_d) begin
                gate_en <= 1'b1;
            end
        end
    end

    assign gate        = (state == LOCKED) && (gate_en || vs_rise_d);
    assign locked      = (state == LOCKED);
    assign frame_start = vs_rise_d && (state == LOCKED);

    assign o_vsync = vs_p2;
    assign o_hsync = hs_p2;
    assign o_de    = de_p2 & gate;
    assign o_pixel = pix_p2;

endmodule
